// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between instruction fetch and data
// access: data wins ties, fetch starvation is bounded, and hung transactions time out.
module unified_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT     = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_data_o,
  output logic        if_ack_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  output logic [31:0] d_rdata_o,
  output logic        d_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);

  state_t      state;
  logic        owner;  // 0 = fetch, 1 = data
  logic [3:0]  starve_cnt;
  logic [7:0]  wait_cnt;
  logic        grant_d;
  logic        grant_if;
  logic        done;
  logic        timeout;
  logic [31:0] resp_data;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    grant_d  = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      if (d_req_i && !(if_req_i && starve_cnt == STARVE_MAX)) grant_d = 1'b1;
      else if (if_req_i)                                       grant_if = 1'b1;
    end
  end

  // A memory ack landing on the final wait cycle is a normal completion, not a timeout.
  assign done      = (state == BUSY) && mem_ack_i;
  assign timeout   = (state == BUSY) && !mem_ack_i && (wait_cnt == WAIT_LAST);
  assign resp_data = (mem_ack_i && !mem_we_o) ? mem_rdata_i : 32'h0;
  assign stall_o   = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      owner       <= 1'b0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_data_o   <= '0;
      if_ack_o    <= 1'b0;
      d_rdata_o   <= '0;
      d_ack_o     <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d || grant_if) begin
            owner       <= grant_d;
            mem_req_o   <= 1'b1;
            mem_we_o    <= grant_d & d_we_i;
            mem_addr_o  <= grant_d ? d_addr_i : if_addr_i;
            mem_wdata_o <= grant_d ? d_wdata_i : 32'h0;
            wait_cnt    <= '0;
            state       <= BUSY;
            if (grant_if)
              starve_cnt <= '0;
            else if (if_req_i && starve_cnt < STARVE_MAX)
              starve_cnt <= starve_cnt + 4'd1;
          end
        end
        BUSY: begin
          if (done || timeout) begin
            mem_req_o <= 1'b0;
            if (owner) begin
              d_rdata_o <= resp_data;
              d_ack_o   <= 1'b1;
            end else begin
              if_data_o <= resp_data;
              if_ack_o  <= 1'b1;
            end
            if (timeout) err_o <= 1'b1;
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
